// File: rtl/ahb_subordinate_synth.sv
// ---------------------------------------------------------------------------
// ahb_subordinate_synth
//
// AHB-Lite subordinate backed by a small register-file memory of Depth
// 32-bit words, starting at byte address BaseAddress. Each data phase is
// stretched by a fixed number of wait states (WaitStates, 0..7). Byte,
// halfword and word writes are merged into the addressed word little-endian.
// Reads return the full addressed word.
//
// Transfers that fall outside the memory window, use HSIZE > 2 or are
// misaligned are "invalid": they never touch memory.
//
// Optional feature macro: AHB_SUBORDINATE_ERROR_RESP_EN
//   defined   -> invalid transfers end with the two-cycle AHB ERROR response
//                (ERR1: HREADYOUT=0/HRESP=1, ERR2: HREADYOUT=1/HRESP=1).
//   undefined -> invalid transfers complete OKAY with normal wait timing,
//                writes are dropped and reads return zero.
//
// Ports
//   HCLK       in   1             clock, rising edge
//   HRESET     in   1             synchronous active-high reset
//   HSEL       in   1             subordinate select
//   HADDR      in   AddressWidth  byte address (address phase)
//   HTRANS     in   2             IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//   HWRITE     in   1             1 = write (address phase)
//   HSIZE      in   3             0 byte, 1 halfword, 2 word
//   HWDATA     in   DataWidth     write data (data phase)
//   HREADY     in   1             bus ready, previous data phase done
//   HREADYOUT  out  1             this subordinate's data phase completes
//   HRESP      out  1             0 OKAY, 1 ERROR
//   HRDATA     out  DataWidth     read data, valid in completing cycle only
//
// Only DataWidth = 32 is supported; Depth must be a power of two >= 2 and
// BaseAddress must be aligned to Depth*4 bytes.
// ---------------------------------------------------------------------------
module ahb_subordinate_synth #(
  parameter int                      AddressWidth = 32,
  parameter int                      DataWidth    = 32,
  parameter int                      Depth        = 16,
  parameter logic [AddressWidth-1:0] BaseAddress  = '0,
  parameter int                      WaitStates   = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [AddressWidth-1:0] HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [DataWidth-1:0]    HWDATA,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DataWidth-1:0]    HRDATA
);

  localparam int IdxW = $clog2(Depth);

`ifdef AHB_SUBORDINATE_ERROR_RESP_EN
  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWait} state_e;
`endif

  state_e                 state_q;
  logic [2:0]             waitCnt_q;
  logic                   pending_q;
  logic                   write_q;
  logic                   invalid_q;
  logic [1:0]             size_q;
  logic [1:0]             lane_q;
  logic [IdxW-1:0]        idx_q;
  logic                   readyOut_q;
  logic                   resp_q;
  logic [DataWidth-1:0]   mem_q [Depth];

  logic [AddressWidth-1:0] offset;
  logic                    inRange;
  logic                    sizeOk;
  logic                    alignOk;
  logic                    addrInvalid;
  logic                    accept;
  logic                    complete;
  logic                    commit;
  logic [3:0]              strobe;
  logic [DataWidth-1:0]    memWord_d;
  logic                    unusedTrans;

  assign unusedTrans = HTRANS[0];

  // Address decode. Subtracting the base makes addresses below the window
  // wrap to huge offsets, so a single "upper bits are zero" test covers both
  // ends of the window. BaseAddress is window-aligned, so the low offset bits
  // equal the low HADDR bits.
  assign offset  = HADDR - BaseAddress;
  assign inRange = (offset[AddressWidth-1:IdxW+2] == '0);
  assign sizeOk  = (HSIZE <= 3'd2);
  assign alignOk = (HSIZE == 3'd0) ||
                   (HSIZE == 3'd1 && offset[0] == 1'b0) ||
                   (HSIZE == 3'd2 && offset[1:0] == 2'b00);
  assign addrInvalid = !(inRange && sizeOk && alignOk);

  // A new address phase is only taken while the FSM sits in IDLE. The only
  // cycles where HREADY can legally be high outside IDLE are ERR2 cycles,
  // and a manager cancels the transfer it shows there.
  assign accept = (state_q == StIdle) && HSEL && HREADY && HTRANS[1] && !HRESET;

  // The completing cycle of a data phase is an IDLE cycle with a pending
  // transfer; wait states and error cycles are all spent in other states.
  assign complete = (state_q == StIdle) && pending_q;
  assign commit   = complete && write_q && !invalid_q && !HRESET;

  // Byte-lane enables for the write in flight, little-endian.
  always_comb begin
    strobe = 4'b0000;
    case (size_q)
      2'd0:    strobe = 4'b0001 << lane_q;
      2'd1:    strobe = lane_q[1] ? 4'b1100 : 4'b0011;
      default: strobe = 4'b1111;
    endcase
  end

  // Merge the enabled HWDATA lanes into the currently stored word; disabled
  // lanes keep their old contents.
  always_comb begin
    memWord_d = mem_q[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) begin
        memWord_d[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Memory array. Deliberately not cleared by reset; a reset only drops the
  // pending data phase, which the commit term already accounts for.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      mem_q[idx_q] <= memWord_d;
    end
  end

  // Transfer-sequencing FSM. HREADYOUT and HRESP are registered here so the
  // value for each cycle is decided at the edge that starts it. In IDLE a
  // completing transfer and a newly accepted one overlap, which is what lets
  // back-to-back transfers run without an idle gap.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      waitCnt_q  <= 3'd0;
      pending_q  <= 1'b0;
      write_q    <= 1'b0;
      invalid_q  <= 1'b0;
      size_q     <= 2'd0;
      lane_q     <= 2'd0;
      idx_q      <= '0;
      readyOut_q <= 1'b1;
      resp_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            pending_q <= 1'b1;
            write_q   <= HWRITE;
            invalid_q <= addrInvalid;
            size_q    <= HSIZE[1:0];
            lane_q    <= offset[1:0];
            idx_q     <= offset[IdxW+1:2];
            if (WaitStates != 0) begin
              state_q    <= StWait;
              waitCnt_q  <= 3'(WaitStates - 1);
              readyOut_q <= 1'b0;
              resp_q     <= 1'b0;
            end else begin
              state_q    <= StIdle;
              readyOut_q <= 1'b1;
              resp_q     <= 1'b0;
`ifdef AHB_SUBORDINATE_ERROR_RESP_EN
              if (addrInvalid) begin
                state_q    <= StErr1;
                readyOut_q <= 1'b0;
                resp_q     <= 1'b1;
              end
`endif
            end
          end else begin
            pending_q  <= 1'b0;
            readyOut_q <= 1'b1;
            resp_q     <= 1'b0;
          end
        end

        StWait: begin
          if (waitCnt_q != 3'd0) begin
            waitCnt_q <= waitCnt_q - 3'd1;
          end else begin
            state_q    <= StIdle;
            readyOut_q <= 1'b1;
            resp_q     <= 1'b0;
`ifdef AHB_SUBORDINATE_ERROR_RESP_EN
            if (invalid_q) begin
              state_q    <= StErr1;
              readyOut_q <= 1'b0;
              resp_q     <= 1'b1;
            end
`endif
          end
        end

`ifdef AHB_SUBORDINATE_ERROR_RESP_EN
        StErr1: begin
          state_q    <= StErr2;
          readyOut_q <= 1'b1;
          resp_q     <= 1'b1;
        end

        StErr2: begin
          state_q    <= StIdle;
          pending_q  <= 1'b0;
          readyOut_q <= 1'b1;
          resp_q     <= 1'b0;
        end
`endif

        default: begin
          state_q    <= StIdle;
          pending_q  <= 1'b0;
          readyOut_q <= 1'b1;
          resp_q     <= 1'b0;
        end
      endcase
    end
  end

  assign HREADYOUT = readyOut_q;
  assign HRESP     = resp_q;

  // Read data comes straight from the array during the completing cycle. A
  // write finishing in the previous cycle has already landed by then, so a
  // read right after a write sees the new data without a bypass path.
  assign HRDATA = (complete && !write_q && !invalid_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_subordinate_synth.sv
// ---------------------------------------------------------------------------
// tb_ahb_subordinate_synth
//
// Two subordinates on two independent single-subordinate buses: bus 0 has no
// wait states, bus 1 has three. HREADY of each bus is that subordinate's own
// HREADYOUT. Expected data comes from a byte-addressed memory image per bus.
// ---------------------------------------------------------------------------
module tb_ahb_subordinate_synth;

`ifdef AHB_SUBORDINATE_ERROR_RESP_EN
  localparam bit ErrMode = 1'b1;
`else
  localparam bit ErrMode = 1'b0;
`endif
  localparam int SpanBytes = 64;

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] expR;
    logic        inv;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  logic [7:0]  memBytes [2][SpanBytes];
  vec_t        vecs [17];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 HCLK = ~HCLK;

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_subordinate_synth #(.WaitStates(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HWDATA(hwdata[0]), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]), .HRDATA(hrdata[0])
  );

  ahb_subordinate_synth #(.WaitStates(3)) dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HWDATA(hwdata[1]), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]), .HRDATA(hrdata[1])
  );

  function automatic int waitOf(input int b);
    return (b == 0) ? 0 : 3;
  endfunction

  // A transfer is legal when it lies in the window, is at most a word wide
  // and its address is a multiple of its size.
  function automatic bit isValid(input logic [31:0] ad, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b0;
    if (ad >= 32'(SpanBytes)) return 1'b0;
    if ((ad % (32'd1 << sz)) != 32'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] modelRead(input int b, input logic [31:0] ad);
    int base;
    base = int'(ad) & ~3;
    return {memBytes[b][base+3], memBytes[b][base+2], memBytes[b][base+1], memBytes[b][base]};
  endfunction

  // Each byte address of the transfer takes the HWDATA lane it lives on.
  task automatic modelWrite(input int b, input logic [31:0] ad, input logic [2:0] sz, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) begin
      int a;
      a = int'(ad) + i;
      memBytes[b][a] = wd[8*(a % 4) +: 8];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic busIdle(input int b);
    hsel[b]   = 1'b0;
    htrans[b] = 2'b00;
    haddr[b]  = 32'h0;
    hwrite[b] = 1'b0;
    hsize[b]  = 3'd0;
    hwdata[b] = 32'h0;
  endtask

  // One non-pipelined transfer, entered and left just after a rising edge.
  task automatic applyStimulus(input int b, input logic wr, input logic [2:0] sz,
                               input logic [31:0] ad, input logic [31:0] wd,
                               output logic [31:0] rd, output logic rs,
                               output int lows, output logic timedOut);
    bit done;
    hsel[b]   = 1'b1;
    htrans[b] = 2'b10;
    haddr[b]  = ad;
    hwrite[b] = wr;
    hsize[b]  = sz;
    @(posedge HCLK); #1;
    busIdle(b);
    hwdata[b] = wd;
    rd = 32'h0; rs = 1'b0; lows = 0; timedOut = 1'b0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge HCLK);
      if (hreadyout[b]) begin
        rd = hrdata[b];
        rs = hresp[b];
        done = 1'b1;
      end else begin
        lows++;
        checkOutput("hrdata in wait", hrdata[b], 32'h0);
        @(posedge HCLK); #1;
      end
    end
    if (!done) timedOut = 1'b1;
    @(posedge HCLK); #1;
    hwdata[b] = 32'h0;
  endtask

  task automatic doChecked(input int b, input string tag, input logic wr, input logic [2:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd,
                           input logic [31:0] expR, input logic expResp);
    logic [31:0] rd;
    logic        rs;
    int          lows;
    logic        to;
    applyStimulus(b, wr, sz, ad, wd, rd, rs, lows, to);
    checkOutput({tag, " timeout"}, 32'(to), 32'h0);
    checkOutput({tag, " hrdata"}, rd, expR);
    checkOutput({tag, " hresp"}, 32'(rs), 32'(expResp));
    checkOutput({tag, " waits"}, 32'(lows), 32'(waitOf(b) + (expResp ? 1 : 0)));
  endtask

  task automatic modelTransfer(input int b, input string tag, input logic wr, input logic [2:0] sz,
                               input logic [31:0] ad, input logic [31:0] wd);
    bit          valid;
    logic [31:0] expR;
    valid = isValid(ad, sz);
    expR  = (!wr && valid) ? modelRead(b, ad) : 32'h0;
    doChecked(b, tag, wr, sz, ad, wd, expR, ErrMode && !valid);
    if (wr && valid) modelWrite(b, ad, sz, wd);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] m0;
    logic [31:0] m1;

    vecs[0]  = '{1'b1, 3'd2, 32'h04, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'd2, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 3'd2, 32'h08, 32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 3'd0, 32'h09, 32'h0000AA00, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 3'd2, 32'h08, 32'h0,        32'h1122AA44, 1'b0};
    vecs[5]  = '{1'b1, 3'd2, 32'h0C, 32'h55667788, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 3'd1, 32'h0E, 32'hBEEF0000, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 3'd2, 32'h0C, 32'h0,        32'hBEEF7788, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 3'd2, 32'h40, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 3'd1, 32'h05, 32'h12345678, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 3'd2, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b1, 3'd3, 32'h10, 32'h87654321, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 3'd2, 32'h3C, 32'h0BADF00D, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 3'd2, 32'h3C, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 32'h3F, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[16] = '{1'b0, 3'd2, 32'h06, 32'h0,        32'h0,        1'b1};

    busIdle(0);
    busIdle(1);
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    for (int b = 0; b < 2; b++) begin
      checkOutput("reset hreadyout", 32'(hreadyout[b]), 32'h1);
      checkOutput("reset hresp", 32'(hresp[b]), 32'h0);
      checkOutput("reset hrdata", hrdata[b], 32'h0);
    end
    @(posedge HCLK); #1;

    // Give every word a known value on both buses.
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < SpanBytes / 4; w++) begin
        modelTransfer(b, "init", 1'b1, 3'd2, 32'(w * 4), $urandom);
      end
    end

    // Directed table on the zero-wait bus.
    for (int i = 0; i < 17; i++) begin
      doChecked(0, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].ad,
                vecs[i].wd, vecs[i].expR, ErrMode && vecs[i].inv);
      if (vecs[i].wr && !vecs[i].inv) modelWrite(0, vecs[i].ad, vecs[i].sz, vecs[i].wd);
    end

    // BUSY with HSEL=1, then NONSEQ with HSEL=0, both as writes: no effect.
    hsel[0] = 1'b1; htrans[0] = 2'b01; hwrite[0] = 1'b1; haddr[0] = 32'h04; hsize[0] = 3'd2;
    @(posedge HCLK); #1;
    hwdata[0] = 32'hFFFFFFFF;
    hsel[0] = 1'b0; htrans[0] = 2'b10;
    @(negedge HCLK);
    checkOutput("busy hreadyout", 32'(hreadyout[0]), 32'h1);
    checkOutput("busy hresp", 32'(hresp[0]), 32'h0);
    @(posedge HCLK); #1;
    busIdle(0);
    hwdata[0] = 32'hFFFFFFFF;
    @(negedge HCLK);
    checkOutput("unsel hreadyout", 32'(hreadyout[0]), 32'h1);
    checkOutput("unsel hresp", 32'(hresp[0]), 32'h0);
    @(posedge HCLK); #1;
    busIdle(0);
    modelTransfer(0, "after busy", 1'b0, 3'd2, 32'h04, 32'h0);

    // Write immediately followed by a pipelined read of the same word.
    x = $urandom;
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h10; hsize[0] = 3'd2;
    @(posedge HCLK); #1;
    hwdata[0] = x;
    hwrite[0] = 1'b0;
    @(negedge HCLK);
    checkOutput("raw write ready", 32'(hreadyout[0]), 32'h1);
    @(posedge HCLK); #1;
    busIdle(0);
    @(negedge HCLK);
    checkOutput("raw read ready", 32'(hreadyout[0]), 32'h1);
    checkOutput("raw read data", hrdata[0], x);
    @(posedge HCLK); #1;
    modelWrite(0, 32'h10, 3'd2, x);

    // Three-wait bus: read 0x00 with a read of 0x04 held behind it.
    m0 = modelRead(1, 32'h00);
    m1 = modelRead(1, 32'h04);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b0; haddr[1] = 32'h00; hsize[1] = 3'd2;
    @(posedge HCLK); #1;
    haddr[1] = 32'h04;
    for (int k = 0; k < 8; k++) begin
      @(negedge HCLK);
      checkOutput($sformatf("pipe ready c%0d", k), 32'(hreadyout[1]), 32'((k % 4) == 3));
      checkOutput($sformatf("pipe data c%0d", k), hrdata[1],
                  (k == 3) ? m0 : ((k == 7) ? m1 : 32'h0));
      @(posedge HCLK); #1;
      if (k == 3) busIdle(1);
    end

    // Reset during the second wait cycle of a write to 0x0C.
    x = modelRead(1, 32'h0C);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h0C; hsize[1] = 3'd2;
    @(posedge HCLK); #1;
    busIdle(1);
    hwdata[1] = ~x;
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    checkOutput("abort hreadyout", 32'(hreadyout[1]), 32'h1);
    checkOutput("abort hresp", 32'(hresp[1]), 32'h0);
    @(posedge HCLK); #1;
    busIdle(1);
    modelTransfer(1, "after abort", 1'b0, 3'd2, 32'h0C, 32'h0);

    // Random traffic on both buses.
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < 40; n++) begin
        modelTransfer(b, $sformatf("rand b%0d n%0d", b, n), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 3)), 32'($urandom_range(0, 79)), $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
